of_hazard_scheduler: RTL and testbench
======================================

# of_hazard_scheduler

Issue scheduler for the operand-fetch stage of the SimpleRISC pipeline. It keeps a per-register scoreboard of in-flight writes between issue and register-file writeback, and holds the OF stage while any needed source register is still pending. It also sequences the halt drain: once a `stop` instruction issues, no further issue is allowed, and `halted` asserts after every pending write has retired. It sits between decode/OF and the writeback port that feeds the register file.

## Interface
Parameters:
- `NREG`, 32: architectural registers; `AW` = $clog2(`NREG`).
- `CNT_W`, 2: width of each pending counter; up to 2^`CNT_W`-1 writes in flight per register.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `of_valid` in 1: OF holds a decoded instruction.
- `rp1`, `rp2` in `AW`: source register addresses, already muxed for ret/st.
- `rp1_used`, `rp2_used` in 1: the corresponding source is actually read.
- `rd` in `AW`: destination register.
- `rd_wr` in 1: the instruction writes `rd`.
- `is_stop` in 1: the instruction is `stop`.
- `wb_en` in 1: a writeback retires this cycle.
- `wb_addr` in `AW`: register being written back.
- `flush` in 1: discard all in-flight state.
- `of_ready` out 1: issue permitted; issue occurs when `of_valid & of_ready`.
- `stall` out 1: equals `of_valid & ~of_ready`.
- `pending_any` out 1: any counter is nonzero.
- `halted` out 1: FSM is in HALTED.
- `fwd1`, `fwd2` out 1: only present under the macro.

## Operation
- Each register has a counter `cnt[r]`. On issue with `rd_wr`, `cnt[rd]` increments. On `wb_en`, `cnt[wb_addr]` decrements.
- If an increment and a decrement hit the same register in the same cycle, its count is unchanged.
- A decrement at zero is ignored (treated as a protocol error; must never happen).
- Hazard on a source: `rpN_used & cnt[rpN] != 0`.
- Structural stall: `rd_wr & cnt[rd] == CNT_MAX`. Issue never saturates or wraps a counter.
- `of_ready` = state RUN & no hazard & no structural stall.
- FSM states:
  - RUN: normal issue. An issue with `is_stop` moves to DRAIN.
  - DRAIN: `of_ready` = 0. Moves to HALTED in the cycle after `pending_any` is observed 0.
  - HALTED: `of_ready` = 0, `halted` = 1. Left only via `rst` or `flush`.
- `flush`:
  - Clears every counter and moves to RUN next cycle.
  - Overrides any issue or `wb_en` in the same cycle; `of_ready` is forced to 0 while `flush` is high.
- `rst` has the same effect as `flush`, and also forces the outputs to their reset values.
- A mid-drain reset or flush returns to RUN with an empty scoreboard.

## Timing
- `of_ready`, `stall`, `fwd*`: combinational from inputs, counters and state; zero latency.
- Counters and FSM update on the rising edge after the qualifying event.
- A writeback clears a hazard in the cycle after `wb_en`; this is the base configuration.
- Reset values: all counters 0, state RUN, `pending_any` 0, `halted` 0, `fwd1`/`fwd2` 0.
  - `of_ready` follows `of_valid` conditions once `rst` is low; it is 0 while `rst` is high.
- `pending_any` and `halted` are derived from registered state only.

## Configuration
- `OF_SCHED_FWD_EN` defined: same-cycle writeback bypass.
  - A source with `cnt` == 1 that matches `wb_addr` while `wb_en` is high is not a hazard.
  - The matching `fwdN` output is 1, telling OF to take WriteData instead of the file output.
  - Hazards therefore clear in the writeback cycle itself.
- `OF_SCHED_FWD_EN` undefined: no bypass; `fwd1`/`fwd2` ports are absent; a hazard clears one cycle after writeback.

## Structure
- Package `of_sched_pkg` holds:
  - the FSM state enum (RUN, DRAIN, HALTED);
  - `CNT_MAX` = 2^`CNT_W`-1;
  - the default `NREG`/`AW` localparams.
- Sub-module `sb_counter`: one pending counter with inc/dec/clr inputs, a saturation flag and a nonzero flag. It is instantiated `NREG` times via generate.
- Hazard compare, `of_ready` logic and the FSM live in the top module.

## Test plan
- Scenario 1, hazard then release.
  - Stimulus: issue r3 writer; next cycle `of_valid` with `rp1`=3 used; `wb_en`, `wb_addr`=3 two cycles later.
  - Required: `stall` held until `cnt[3]` = 0. Issue on the cycle after wb (base) or the wb cycle with `fwd1`=1 (macro).
- Scenario 2, saturation.
  - Stimulus: three issues with `rd`=5, no writeback, then a fourth writer to r5.
  - Required: `of_ready` = 0 for the fourth; one wb to r5 re-enables it.
- Scenario 3, simultaneous events.
  - Stimulus: issue writer `rd`=7 while `wb_en`, `wb_addr`=7 with `cnt[7]`=1.
  - Required: `cnt[7]` stays 1 and `pending_any` stays 1.
- Scenario 4, halt drain.
  - Stimulus: two writers in flight, then issue `stop`; retire both writes.
  - Required: `of_ready` = 0 from the next cycle; `halted` = 1 exactly one cycle after `pending_any` falls; a new `of_valid` is never issued.
- Scenario 5, flush mid-drain.
  - Stimulus: in DRAIN with `cnt[2]`=1, assert `flush` together with `wb_en`/`wb_addr`=2.
  - Required: next cycle state RUN, all counters 0, `pending_any` = 0, and the wb is ignored without underflow.
- Scenario 6, reset.
  - Stimulus: assert `rst` with `of_valid` and pending writes present.
  - Required: `of_ready` = 0 during `rst`; after release, all counters 0, `halted` 0, and an independent instruction issues immediately.

Source files
------------

// File: rtl/of_sched_pkg.sv
// Shared types and constants for the operand-fetch issue scheduler.
package of_sched_pkg;

    localparam int NREG_DEF  = 32;
    localparam int AW_DEF    = $clog2(NREG_DEF);
    localparam int CNT_W_DEF = 2;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } sched_state_e;

    // Largest value a pending counter of the given width may hold.
    function automatic int cnt_max_of(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/of_hazard_scheduler_sb_counter.sv
// One per-register pending-write counter. Clear wins over everything;
// a simultaneous inc and dec leave the count unchanged; a dec at zero and
// an inc at saturation are both ignored so the count never wraps.
module sb_counter
    import of_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             nz
);

    logic [CNT_W-1:0] count_r;

    // Pending-write count update.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= CNT_W'(0);
        end else if (inc && !dec && !sat) begin
            count_r <= count_r + CNT_W'(1);
        end else if (dec && !inc && nz) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign sat   = (count_r == CNT_W'(cnt_max_of(CNT_W)));
    assign nz    = (count_r != CNT_W'(0));

endmodule

// File: rtl/of_hazard_scheduler.sv
// Operand-fetch issue scheduler: per-register scoreboard of in-flight
// writes, source-hazard and structural stalls, and the stop/halt drain.
// Optional feature: define OF_SCHED_FWD_EN for same-cycle writeback bypass
// (adds fwd1/fwd2 outputs).
module of_hazard_scheduler
    import of_sched_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int AW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          of_valid,
    input  logic [AW-1:0] rp1,
    input  logic [AW-1:0] rp2,
    input  logic          rp1_used,
    input  logic          rp2_used,
    input  logic [AW-1:0] rd,
    input  logic          rd_wr,
    input  logic          is_stop,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic          flush,
    output logic          of_ready,
    output logic          stall,
    output logic          pending_any,
    output logic          halted
`ifdef OF_SCHED_FWD_EN
    ,
    output logic          fwd1,
    output logic          fwd2
`endif
);

    sched_state_e                 state_r;
    sched_state_e                 state_nxt_s;
    logic [NREG-1:0]              nz_s;
    logic [NREG-1:0]              sat_s;
    logic [NREG-1:0][CNT_W-1:0]   cnt_s;
    logic                         clr_s;
    logic                         issue_s;
    logic                         haz1_s;
    logic                         haz2_s;
    logic                         struct_s;
    logic                         fwd1_s;
    logic                         fwd2_s;

    // Reset and flush both empty the scoreboard; the flush also masks the
    // same-cycle writeback so a cleared counter is never decremented.
    assign clr_s   = rst | flush;
    assign issue_s = of_valid & of_ready;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .clr   (clr_s),
                .inc   (issue_s & rd_wr & (rd == AW'(i))),
                .dec   (wb_en & ~flush & (wb_addr == AW'(i))),
                .count (cnt_s[i]),
                .sat   (sat_s[i]),
                .nz    (nz_s[i])
            );
        end
    endgenerate

    // Source hazards, structural stall and issue permission.
    always_comb begin
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
`ifdef OF_SCHED_FWD_EN
        // Last outstanding write to a source retiring now: take WriteData.
        fwd1_s = ~rst & rp1_used & wb_en & (wb_addr == rp1) & (cnt_s[rp1] == CNT_W'(1));
        fwd2_s = ~rst & rp2_used & wb_en & (wb_addr == rp2) & (cnt_s[rp2] == CNT_W'(1));
`endif
        haz1_s   = rp1_used & nz_s[rp1] & ~fwd1_s;
        haz2_s   = rp2_used & nz_s[rp2] & ~fwd2_s;
        struct_s = rd_wr & sat_s[rd];
        of_ready = ~rst & ~flush & (state_r == ST_RUN) & ~haz1_s & ~haz2_s & ~struct_s;
        stall    = of_valid & ~of_ready;
    end

`ifdef OF_SCHED_FWD_EN
    assign fwd1 = fwd1_s;
    assign fwd2 = fwd2_s;
`endif

    // Halt-drain state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Halt-drain next state: stop enters DRAIN, an empty scoreboard ends it.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (issue_s && is_stop) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!pending_any) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_HALTED: state_nxt_s = ST_HALTED;
                default:   state_nxt_s = ST_RUN;
            endcase
        end
    end

    assign pending_any = |cnt_s;
    assign halted      = (state_r == ST_HALTED);

endmodule

// File: tb/tb_of_hazard_scheduler.sv
// Self-checking bench for of_hazard_scheduler: a per-register count model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_of_hazard_scheduler;

    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef OF_SCHED_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          of_valid;
    logic [AW-1:0] rp1;
    logic [AW-1:0] rp2;
    logic          rp1_used;
    logic          rp2_used;
    logic [AW-1:0] rd;
    logic          rd_wr;
    logic          is_stop;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic          flush;
    logic          of_ready;
    logic          stall;
    logic          pending_any;
    logic          halted;
`ifdef OF_SCHED_FWD_EN
    logic          fwd1;
    logic          fwd2;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: outstanding writes per register plus drain/halt flags.
    int mcnt[NREG];
    bit m_drain = 1'b0;
    bit m_halt  = 1'b0;
    bit m_live  = 1'b0;

    of_hazard_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .of_valid    (of_valid),
        .rp1         (rp1),
        .rp2         (rp2),
        .rp1_used    (rp1_used),
        .rp2_used    (rp2_used),
        .rd          (rd),
        .rd_wr       (rd_wr),
        .is_stop     (is_stop),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .of_ready    (of_ready),
        .stall       (stall),
        .pending_any (pending_any),
        .halted      (halted)
`ifdef OF_SCHED_FWD_EN
        ,
        .fwd1        (fwd1),
        .fwd2        (fwd2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic bit m_fwd(input logic used, input logic [AW-1:0] a);
        return FWD_ON && !rst && used && wb_en && (wb_addr == a) && (mcnt[a] == 1);
    endfunction

    function automatic bit m_ready();
        if (rst || flush || m_drain || m_halt) return 1'b0;
        if (rp1_used && mcnt[rp1] != 0 && !m_fwd(rp1_used, rp1)) return 1'b0;
        if (rp2_used && mcnt[rp2] != 0 && !m_fwd(rp2_used, rp2)) return 1'b0;
        if (rd_wr && mcnt[rd] == 3) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_pending();
        for (int i = 0; i < NREG; i++) if (mcnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Model update at each rising edge from the inputs held across it.
    always @(posedge clk) begin
        bit rdy;
        bit pend;
        bit iss;
        rdy  = m_ready();
        pend = m_pending();
        if (rst || flush) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            m_drain = 1'b0;
            m_halt  = 1'b0;
        end else begin
            iss = of_valid && rdy;
            if (m_drain && !pend) begin
                m_drain = 1'b0;
                m_halt  = 1'b1;
            end
            if (iss && is_stop) m_drain = 1'b1;
            if (!(iss && rd_wr && wb_en && rd == wb_addr)) begin
                if (iss && rd_wr) mcnt[rd]++;
                if (wb_en && mcnt[wb_addr] > 0) mcnt[wb_addr]--;
            end
        end
        if (rst) m_live = 1'b1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("of_ready", of_ready, m_ready());
            check("stall", stall, of_valid && !m_ready());
            check("pending_any", pending_any, m_pending());
            check("halted", halted, m_halt);
`ifdef OF_SCHED_FWD_EN
            check("fwd1", fwd1, m_fwd(rp1_used, rp1));
            check("fwd2", fwd2, m_fwd(rp2_used, rp2));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        of_valid = 1'b0; rp1 = 5'd0; rp2 = 5'd0; rp1_used = 1'b0; rp2_used = 1'b0;
        rd = 5'd0; rd_wr = 1'b0; is_stop = 1'b0; wb_en = 1'b0; wb_addr = 5'd0;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        of_valid = 1'b1; rd = 5'd4; rd_wr = 1'b1;
        step(); step();
        #1 check("rst_ready", of_ready, 1'b0);
        check("rst_stall", stall, 1'b1);
        check("rst_halted", halted, 1'b0);
        rst = 1'b0;
        idle();
        step();

        // Scenario 1: hazard then release.
        of_valid = 1'b1; rd = 5'd3; rd_wr = 1'b1;
        #1 check("s1_issue", of_ready, 1'b1);
        step();
        rd_wr = 1'b0; rp1 = 5'd3; rp1_used = 1'b1;
        #1 check("s1_hazard", stall, 1'b1);
        step();
        #1 check("s1_hold", stall, 1'b1);
        step();
        wb_en = 1'b1; wb_addr = 5'd3;
        #1 check("s1_wb_cycle", stall, !FWD_ON);
`ifdef OF_SCHED_FWD_EN
        check("s1_fwd1", fwd1, 1'b1);
`endif
        step();
        wb_en = 1'b0;
        #1 check("s1_release", of_ready, 1'b1);
        step();
        idle();

        // Scenario 2: saturation.
        of_valid = 1'b1; rd = 5'd5; rd_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("s2_fill", of_ready, 1'b1);
            step();
        end
        #1 check("s2_sat", of_ready, 1'b0);
        step();
        wb_en = 1'b1; wb_addr = 5'd5;
        #1 check("s2_sat_wb", of_ready, 1'b0);
        step();
        wb_en = 1'b0;
        #1 check("s2_reenable", of_ready, 1'b1);
        step();
        of_valid = 1'b0; rd_wr = 1'b0; wb_en = 1'b1; wb_addr = 5'd5;
        step(); step(); step();
        wb_en = 1'b0;
        #1 check("s2_empty", pending_any, 1'b0);
        step();

        // Scenario 3: simultaneous inc and dec on r7.
        of_valid = 1'b1; rd = 5'd7; rd_wr = 1'b1;
        step();
        wb_en = 1'b1; wb_addr = 5'd7;
        #1 check("s3_ready", of_ready, 1'b1);
        step();
        rd_wr = 1'b0; rp1 = 5'd7; rp1_used = 1'b1; wb_en = 1'b0;
        #1 check("s3_pending", pending_any, 1'b1);
        check("s3_still_hazard", stall, 1'b1);
        step();
        of_valid = 1'b0; rp1_used = 1'b0; wb_en = 1'b1; wb_addr = 5'd7;
        step();
        wb_en = 1'b0;
        #1 check("s3_single", pending_any, 1'b0);
        step();

        // Scenario 4: halt drain.
        of_valid = 1'b1; rd = 5'd1; rd_wr = 1'b1;
        step();
        rd = 5'd2;
        step();
        rd_wr = 1'b0; is_stop = 1'b1;
        #1 check("s4_stop_issue", of_ready, 1'b1);
        step();
        is_stop = 1'b0; rd = 5'd9; rd_wr = 1'b1;
        #1 check("s4_blocked", of_ready, 1'b0);
        step();
        wb_en = 1'b1; wb_addr = 5'd1;
        step();
        wb_addr = 5'd2;
        step();
        wb_en = 1'b0;
        #1 check("s4_drained", pending_any, 1'b0);
        check("s4_not_yet", halted, 1'b0);
        step();
        #1 check("s4_halted", halted, 1'b1);
        check("s4_no_issue", of_ready, 1'b0);
        step(); step();

        // Scenario 5: flush out of HALTED, then flush mid-drain.
        flush = 1'b1;
        #1 check("s5_flush_ready", of_ready, 1'b0);
        step();
        flush = 1'b0; of_valid = 1'b1; rd = 5'd2; rd_wr = 1'b1;
        #1 check("s5_run", of_ready, 1'b1);
        step();
        rd_wr = 1'b0; is_stop = 1'b1;
        step();
        is_stop = 1'b0; flush = 1'b1; wb_en = 1'b1; wb_addr = 5'd2;
        #1 check("s5_flush_drain", of_ready, 1'b0);
        step();
        flush = 1'b0; wb_en = 1'b0; rp1 = 5'd2; rp1_used = 1'b1;
        #1 check("s5_pending", pending_any, 1'b0);
        check("s5_halted", halted, 1'b0);
        check("s5_run_again", of_ready, 1'b1);
        step();
        idle();

        // Scenario 6: reset with writes pending.
        of_valid = 1'b1; rd = 5'd4; rd_wr = 1'b1;
        step();
        rd = 5'd6;
        step();
        rst = 1'b1;
        #1 check("s6_rst_ready", of_ready, 1'b0);
        step();
        #1 check("s6_rst_pending", pending_any, 1'b0);
        step();
        rst = 1'b0; rd_wr = 1'b0; rp1 = 5'd4; rp1_used = 1'b1; rp2 = 5'd6; rp2_used = 1'b1;
        #1 check("s6_pending", pending_any, 1'b0);
        check("s6_halted", halted, 1'b0);
        check("s6_issue", of_ready, 1'b1);
        step();
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
